instr_fetch_unit: RTL and testbench

- Instruction fetch stage. It is the producer side of the opcode/funct interface consumed by the control decoder.
- Holds the PC and issues word reads to a synchronous instruction memory with 1-cycle read latency.
- Presents each fetched instruction, pre-split into opcode and funct, through a valid/ready handshake. Buffering is one output register plus a one-entry skid buffer.
- Accepts branch/jump redirects from downstream, flushing the fetch path, and traps misaligned redirect targets.

---
 rtl/instr_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency instruction memory and presents
// opcode/funct-split instructions downstream through an output register backed by a one-entry skid buffer.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [5:0]  out_opcode,
    output logic [5:0]  out_funct,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] fetch_pc;
    logic        rsp_pending;
    logic [31:0] rsp_pc;
    logic        kill;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    logic        issue;
    logic        redirect_act;
    logic        redirect_bad;
    logic        consume;
    logic        out_free;
    logic        rsp_take;
    logic [1:0]  occ_after;
    logic [31:0] src_instr;
    logic [31:0] src_pc;

    // Handshake: a transfer happens on a cycle where out_valid & out_ready; while out_valid is high
    // and out_ready low every out_* signal holds, and out_valid only falls after a transfer or on flush.
    assign consume      = out_valid & out_ready;
    assign out_free     = !out_valid || out_ready;
    assign redirect_act = redirect_valid && (state != S_ERR);
    assign redirect_bad = redirect_act && (redirect_pc[1:0] != 2'b00);
    assign rsp_take     = rsp_pending && !kill;
    assign src_instr    = skid_valid ? skid_instr : imem_rdata;
    assign src_pc       = skid_valid ? skid_pc : rsp_pc;

    always_comb begin
        occ_after = 2'({1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rsp_pending} - {1'b0, consume});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            S_BOOT: begin
                state_nxt = redirect_bad ? S_ERR : S_RUN;
            end
            S_RUN: begin
                if (redirect_bad) begin
                    state_nxt = S_ERR;
                end
                // At most two instructions may be held or in flight once this cycle's transfer drains.
                issue = !redirect_valid && (occ_after < 2'd2);
            end
            S_ERR: begin
                state_nxt = S_ERR;
            end
            default: begin
                state_nxt = S_BOOT;
            end
        endcase
    end

    assign imem_req  = issue;
    assign imem_addr = issue ? fetch_pc : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc     <= RESET_PC;
            rsp_pending  <= 1'b0;
            rsp_pc       <= 32'h0;
            kill         <= 1'b0;
            skid_valid   <= 1'b0;
            skid_instr   <= 32'h0;
            skid_pc      <= 32'h0;
            out_valid    <= 1'b0;
            out_instr    <= 32'h0;
            out_pc       <= 32'h0;
            out_pc4      <= 32'h0;
            misalign_err <= 1'b0;
        end else begin
            rsp_pending <= issue;
            if (issue) begin
                rsp_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (redirect_act) begin
                // Redirect outranks any handshake or response arriving in the same cycle.
                kill       <= 1'b1;
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
                fetch_pc   <= redirect_pc;
                if (redirect_bad) begin
                    misalign_err <= 1'b1;
                end
            end else begin
                kill <= 1'b0;
                if (out_free) begin
                    out_valid <= skid_valid || rsp_take;
                    if (skid_valid || rsp_take) begin
                        out_instr <= src_instr;
                        out_pc    <= src_pc;
                        out_pc4   <= src_pc + 32'd4;
                    end
                    skid_valid <= skid_valid && rsp_take;
                end else begin
                    skid_valid <= skid_valid || rsp_take;
                end
                if (rsp_take && (skid_valid == out_free)) begin
                    skid_instr <= imem_rdata;
                    skid_pc    <= rsp_pc;
                end
            end
        end
    end

    assign out_opcode = out_instr[31:26];
    assign out_funct  = out_instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot timing, backpressure, redirect flush, PC wrap,
// misaligned-redirect trap and asynchronous reset.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [5:0]  out_opcode;
  logic [5:0]  out_funct;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_opcode(out_opcode),
    .out_funct(out_funct),
    .out_pc(out_pc),
    .out_pc4(out_pc4),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .misalign_err(misalign_err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0040) ? 32'h0123_4820 : (a ^ 32'h8C00_0000);
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  // checking helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word(pc);
    chk({tag, " out_valid"}, {31'h0, out_valid}, 32'h1);
    chk({tag, " out_pc"}, out_pc, pc);
    chk({tag, " out_pc4"}, out_pc4, pc + 32'd4);
    chk({tag, " out_instr"}, out_instr, w);
    chk({tag, " out_opcode"}, {26'h0, out_opcode}, {26'h0, w[31:26]});
    chk({tag, " out_funct"}, {26'h0, out_funct}, {26'h0, w[5:0]});
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, " imem_req"}, {31'h0, imem_req}, {31'h0, req});
    if (req) chk({tag, " imem_addr"}, imem_addr, addr);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Releases reset and walks cycles 0..3 of the boot sequence; ends in cycle 3.
  task automatic boot_seq(input string tag);
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    rst            = 1'b0;
    settle();
    chk_req({tag, " c0"}, 1'b0, 32'h0);
    chk({tag, " c0 out_valid"}, {31'h0, out_valid}, 32'h0);
    chk({tag, " c0 misalign"}, {31'h0, misalign_err}, 32'h0);
    chk({tag, " c0 out_pc"}, out_pc, 32'h0);
    chk({tag, " c0 out_pc4"}, out_pc4, 32'h0);
    tick(); settle();
    chk_req({tag, " c1"}, 1'b1, 32'h40);
    chk({tag, " c1 out_valid"}, {31'h0, out_valid}, 32'h0);
    tick(); settle();
    chk_req({tag, " c2"}, 1'b1, 32'h44);
    chk({tag, " c2 out_valid"}, {31'h0, out_valid}, 32'h0);
    tick(); settle();
    chk_out({tag, " c3"}, 32'h40);
    chk({tag, " c3 opcode"}, {26'h0, out_opcode}, 32'h00);
    chk({tag, " c3 funct"}, {26'h0, out_funct}, 32'h20);
    chk({tag, " c3 instr"}, out_instr, 32'h0123_4820);
    chk_req({tag, " c3"}, 1'b1, 32'h48);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(); tick();
    boot_seq("boot");

    // backpressure: out_ready low for cycles 4..9
    tick(); out_ready = 1'b0; settle();
    chk_out("bp c4", 32'h44);
    chk_req("bp c4", 1'b0, 32'h0);
    for (int c = 5; c <= 9; c++) begin
      tick(); settle();
      chk_out("bp hold", 32'h44);
      chk_req("bp hold", 1'b0, 32'h0);
    end
    tick(); out_ready = 1'b1; settle();
    chk_out("bp c10", 32'h44);
    chk_req("bp c10", 1'b1, 32'h4C);
    tick(); settle();
    chk_out("bp c11", 32'h48);
    chk_req("bp c11", 1'b1, 32'h50);
    tick(); settle();
    chk_out("bp c12", 32'h4C);
    chk_req("bp c12", 1'b1, 32'h54);

    // fill the skid buffer, then redirect to 0x100 with a void handshake
    tick(); out_ready = 1'b0; settle();
    chk_out("fill c13", 32'h50);
    chk_req("fill c13", 1'b0, 32'h0);
    tick(); settle();
    chk_out("fill c14", 32'h50);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100; settle();
    chk_req("redir c14", 1'b0, 32'h0);
    tick(); redirect_valid = 1'b0; settle();
    chk("redir t+1 out_valid", {31'h0, out_valid}, 32'h0);
    chk_req("redir t+1", 1'b1, 32'h100);
    tick(); settle();
    chk("redir t+2 out_valid", {31'h0, out_valid}, 32'h0);
    chk_req("redir t+2", 1'b1, 32'h104);
    tick(); settle();
    chk_out("redir t+3", 32'h100);
    chk("redir t+3 opcode", {26'h0, out_opcode}, 32'h23);
    chk("redir t+3 funct", {26'h0, out_funct}, 32'h00);

    // redirect while a response is in flight, to the top of the address space
    tick(); settle();
    chk_out("wrap c18", 32'h104);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; settle();
    chk_req("wrap redir", 1'b0, 32'h0);
    tick(); redirect_valid = 1'b0; settle();
    chk("wrap t+1 out_valid", {31'h0, out_valid}, 32'h0);
    chk_req("wrap t+1", 1'b1, 32'hFFFF_FFF8);
    tick(); settle();
    chk("wrap t+2 out_valid", {31'h0, out_valid}, 32'h0);
    chk_req("wrap t+2", 1'b1, 32'hFFFF_FFFC);
    tick(); settle();
    chk_out("wrap t+3", 32'hFFFF_FFF8);
    chk_req("wrap t+3", 1'b1, 32'h0);
    tick(); settle();
    chk_out("wrap t+4", 32'hFFFF_FFFC);
    chk("wrap pc4 zero", out_pc4, 32'h0);
    chk_req("wrap t+4", 1'b1, 32'h4);
    tick(); settle();
    chk_out("wrap t+5", 32'h0);

    // misaligned redirect traps until reset
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; settle();
    chk_req("mis redir", 1'b0, 32'h0);
    tick(); redirect_valid = 1'b0; settle();
    chk("mis t+1 err", {31'h0, misalign_err}, 32'h1);
    chk("mis t+1 out_valid", {31'h0, out_valid}, 32'h0);
    chk_req("mis t+1", 1'b0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      tick();
      redirect_valid = (c == 2);
      redirect_pc = 32'h200;
      settle();
      chk("mis hold err", {31'h0, misalign_err}, 32'h1);
      chk("mis hold out_valid", {31'h0, out_valid}, 32'h0);
      chk_req("mis hold", 1'b0, 32'h0);
    end
    redirect_valid = 1'b0;
    rst = 1'b1; settle();
    chk("rst clears err", {31'h0, misalign_err}, 32'h0);
    tick();
    boot_seq("reboot");

    // asynchronous reset between clock edges in the middle of a burst
    tick(); settle();
    chk_out("burst c4", 32'h44);
    tick(); settle();
    chk_out("burst c5", 32'h48);
    rst = 1'b1; settle();
    chk("arst imem_req", {31'h0, imem_req}, 32'h0);
    chk("arst imem_addr", imem_addr, 32'h0);
    chk("arst out_valid", {31'h0, out_valid}, 32'h0);
    chk("arst out_instr", out_instr, 32'h0);
    chk("arst out_opcode", {26'h0, out_opcode}, 32'h0);
    chk("arst out_funct", {26'h0, out_funct}, 32'h0);
    chk("arst out_pc", out_pc, 32'h0);
    chk("arst out_pc4", out_pc4, 32'h0);
    chk("arst misalign", {31'h0, misalign_err}, 32'h0);
    tick(); tick();
    boot_seq("post-arst");
    tick(); settle();
    chk_out("post-arst c4", 32'h44);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
